// File: rtl/algorithm_range.sv
// Range stream source: accepts (start, step, count) and emits start, start+step, ...
// on a valid/ready stream. Build macro ALGORITHM_RANGE_SAT_EN enables signed saturation.
module algorithm_range #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] start,
  input  logic [N-1:0] step,
  input  logic [N-1:0] count,
  output logic [N-1:0] sOut,
  output logic         sOut_valid,
  input  logic         sOut_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cur_q, cur_d;
  logic [N-1:0] step_q, step_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] sout_d;
  logic         in_ready_d, out_valid_d, sout_valid_d;
  logic         xfer_c;
  logic [N-1:0] next_val_c;

  assign xfer_c = (state_q == RUN) && sOut_valid && sOut_ready;

`ifdef ALGORITHM_RANGE_SAT_EN
  // Signed overflow only when operands share a sign and the result flips it.
  logic [N-1:0] sum_c;
  logic         ovf_c;
  assign sum_c      = cur_q + step_q;
  assign ovf_c      = (cur_q[N-1] == step_q[N-1]) && (sum_c[N-1] != cur_q[N-1]);
  assign next_val_c = !ovf_c      ? sum_c :
                      cur_q[N-1]  ? {1'b1, {(N-1){1'b0}}} :
                                    {1'b0, {(N-1){1'b1}}};
`else
  assign next_val_c = cur_q + step_q;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (count == '0) ? DONE : RUN;
      RUN:  if (xfer_c && (rem_q == N'(1))) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for datapath and registered outputs
  always_comb begin
    cur_d  = cur_q;
    step_d = step_q;
    rem_d  = rem_q;
    sout_d = sOut;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          step_d = step;
          cur_d  = start;
          rem_d  = count;
          if (count != '0) sout_d = start;
        end
      end
      RUN: begin
        if (xfer_c) begin
          cur_d = next_val_c;
          rem_d = rem_q - N'(1);
          // The final element stays on sOut after the stream drains.
          if (rem_q != N'(1)) sout_d = next_val_c;
        end
      end
      default: ;
    endcase
    in_ready_d   = (state_d == IDLE);
    out_valid_d  = (state_d == DONE);
    sout_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_q      <= '0;
      step_q     <= '0;
      rem_q      <= '0;
      sOut       <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sOut_valid <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      step_q     <= step_d;
      rem_q      <= rem_d;
      sOut       <= sout_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      sOut_valid <= sout_valid_d;
    end
  end

endmodule

// File: doc/algorithm_range.md
Name: algorithm_range

Overview:
- Stream source that sits directly upstream of the sum stage.
- Accepts one request (start, step, count) on the simple-input sync handshake, then emits `count` values start, start+step, start+2*step, ... on a stream output port with valid/ready.
- Signals completion on the block-level out_valid once the last element has been accepted downstream.
- Used to drive algorithm_sum in composed pipelines and benches.

Parameters:
- N, `intN, data width of start, step, count and stream elements.

Ports:
- clk  in  1  clock; all state changes on posedge.
- nrst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- out_valid  out  1  request complete; stream fully drained.
- out_ready  in  1  consumer accepts completion.
- start  in  N  first element value, simple input 0.
- step  in  N  increment per element, simple input 1.
- count  in  N  number of elements, unsigned, simple input 2.
- sOut  out  N  stream data, stream output 0.
- sOut_valid  out  1  sOut holds a valid element.
- sOut_ready  in  1  downstream accepts sOut this cycle.

Behaviour:
- Reset, asynchronous on nrst low, regardless of state:
  - state=IDLE.
  - in_ready=1, out_valid=0, sOut_valid=0, sOut=0.
  - internal remaining=0, cur=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On posedge with in_valid=1: latch step, set cur=start, remaining=count.
  - If count==0, go to DONE; else go to RUN.
  - in_ready deasserts the cycle after acceptance.
- RUN:
  - sOut=cur, sOut_valid=1, asserted the first cycle after acceptance (latency 1).
  - Transfer occurs on a posedge with sOut_valid&&sOut_ready. On transfer: cur<=cur+step, remaining<=remaining-1.
  - If remaining==1 at transfer, go to DONE and deassert sOut_valid next cycle.
  - Without a transfer, sOut and sOut_valid hold stable. Never drop or change an offered element.
  - Back-to-back transfers sustain 1 element/cycle.
- DONE:
  - out_valid=1, sOut_valid=0.
  - On posedge with out_ready=1: go to IDLE, out_valid<=0, in_ready<=1.
  - If in_valid and out_ready are both high in DONE, the new request is not accepted that cycle; it is accepted no earlier than the following cycle in IDLE.
- Arithmetic: cur+step is modulo 2^N (wraps); step is treated as two's complement, so negative steps count down. count is unsigned, max 2^N-1 elements.
- in_valid while not in IDLE is ignored; request inputs are only sampled at acceptance.
- nrst asserted mid-RUN aborts the stream immediately, with no partial completion signalled.
- sOut holds its last value when sOut_valid=0.

Optional Feature:
- Macro: ALGORITHM_RANGE_SAT_EN.
- Defined: cur+step saturates to the signed N-bit range. Positive overflow clamps to 2^(N-1)-1; negative overflow clamps to -2^(N-1). Once saturated, remaining elements repeat the clamped value until count is exhausted.
- Undefined: modulo-2^N wrap as above; no saturation logic synthesized.

Test Plan:
- Reset then request start=1, step=1, count=3, sOut_ready=1 -> sOut 1,2,3 on consecutive cycles starting 1 cycle after acceptance; out_valid the cycle after the last transfer. Chained to algorithm_sum, sum=6.
- count=0, start=5 -> no sOut_valid ever; out_valid=1 one cycle after acceptance.
- start=0, step=1, count=4, sOut_ready toggling 1,0,0,1,1,0,1 -> sOut/sOut_valid stable during stalls; elements 0,1,2,3 each transferred exactly once.
- N=8, start=8'hfe, step=1, count=4 -> without SAT_EN: fe,ff,00,01. With SAT_EN: signed start=-2 gives fe,ff,00,01 (no overflow). Second check start=8'h7e -> 7e,7f,7f,7f.
- start=10, step=8'hfd (-3), count=3 -> sOut 10,7,4.
- nrst low during RUN after 1 transfer -> sOut_valid=0, out_valid=0, in_ready=1 immediately. A new request after release restarts from its own start value.
